// File: rtl/mips_timer_if.sv
// Core MEM-stage data bus as seen by a memory-mapped peripheral.
// The core drives the store strobe, address and data; the peripheral returns the address hit and the read word.
interface mips_timer_if;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] memwritedata;
   logic        sel;
   logic [31:0] rdata;

   modport master (
      output memwrite, memaddr, memwritedata,
      input  sel, rdata
   );

   modport slave (
      input  memwrite, memaddr, memwritedata,
      output sel, rdata
   );
endinterface

// File: rtl/mips_timer.sv
// Memory-mapped down-counting timer with prescaler, one-shot/auto-reload and level irq.
// Reads are combinational on memaddr with zero latency; writes land on the rising edge; the bus never stalls.
module mips_timer #(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100,
   parameter int          PRESC_W   = 16
) (
   input  logic        clk,
   input  logic        reset,
   mips_timer_if.slave bus,
   output logic        irq
);

   logic               r_en;
   logic               r_reload;
   logic               r_irq_en;
   logic [31:0]        r_load;
   logic [31:0]        r_count;
   logic               r_expired;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] r_pcnt;

   logic               w_hit;
   logic [2:0]         w_off;
   logic               w_wr;
   logic               w_wr_ctrl;
   logic               w_wr_load;
   logic               w_wr_count;
   logic               w_wr_status;
   logic               w_wr_presc;
   logic               w_tick;
   logic               w_expire;
   logic               w_en_nxt;
   logic [31:0]        w_rdata;

   assign w_hit       = (bus.memaddr[31:5] == BASE_ADDR[31:5]) && (bus.memaddr[1:0] == 2'b00);
   assign w_off       = bus.memaddr[4:2];
   assign w_wr        = w_hit && bus.memwrite;
   assign w_wr_ctrl   = w_wr && (w_off == 3'd0);
   assign w_wr_load   = w_wr && (w_off == 3'd1);
   assign w_wr_count  = w_wr && (w_off == 3'd2);
   assign w_wr_status = w_wr && (w_off == 3'd3);
   assign w_wr_presc  = w_wr && (w_off == 3'd4);

   assign w_tick   = r_en && (r_pcnt == r_presc);
   assign w_expire = w_tick && (r_count == 32'd0);

   // A software CTRL write overrides the one-shot auto-disable in the same cycle.
   assign w_en_nxt = w_wr_ctrl                 ? bus.memwritedata[0] :
                     (w_expire && !r_reload)   ? 1'b0 : r_en;

   always_comb begin
      w_rdata = 32'd0;
      case (w_off)
         3'd0:    w_rdata = {29'd0, r_irq_en, r_reload, r_en};
         3'd1:    w_rdata = r_load;
         3'd2:    w_rdata = r_count;
         3'd3:    w_rdata = {31'd0, r_expired};
         3'd4:    w_rdata = 32'(r_presc);
         default: w_rdata = 32'd0;
      endcase
   end

   assign bus.sel   = w_hit;
   assign bus.rdata = w_hit ? w_rdata : 32'd0;
   assign irq       = r_expired && r_irq_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en      <= 1'b0;
         r_reload  <= 1'b0;
         r_irq_en  <= 1'b0;
         r_load    <= 32'd0;
         r_count   <= 32'd0;
         r_expired <= 1'b0;
         r_presc   <= '0;
         r_pcnt    <= '0;
      end else begin
         r_en <= w_en_nxt;
         if (w_wr_ctrl) begin
            r_reload <= bus.memwritedata[1];
            r_irq_en <= bus.memwritedata[2];
         end
         if (w_wr_load)
            r_load <= bus.memwritedata;
         if (w_wr_presc)
            r_presc <= bus.memwritedata[PRESC_W-1:0];

         // Software COUNT write discards whatever the tick would have done.
         if (w_wr_count)
            r_count <= bus.memwritedata;
         else if (w_tick) begin
            if (r_count != 32'd0)
               r_count <= r_count - 32'd1;
            else if (r_reload)
               r_count <= r_load;
         end

         r_expired <= w_expire || (r_expired && !(w_wr_status && bus.memwritedata[0]));

         // Holding pcnt at 0 while disabled also covers the clear on an en 0->1 write.
         if (!r_en || !w_en_nxt || w_tick)
            r_pcnt <= '0;
         else
            r_pcnt <= r_pcnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: reset, one-shot, auto-reload, collisions and decode.
module tb_mips_timer;

   localparam logic [31:0] BASE = 32'hFFFF_0100;
   localparam logic [2:0]  CTRL = 3'd0, LOAD = 3'd1, COUNT = 3'd2, STATUS = 3'd3, PRESC = 3'd4;

   logic clk;
   logic reset;
   logic irq;
   int   checks = 0;
   int   errors = 0;

   mips_timer_if bus ();

   mips_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] off, input logic [31:0] exp);
      bus.memwrite = 1'b0;
      bus.memaddr  = BASE + {27'd0, off, 2'b00};
      #1;
      check(tag, bus.rdata, exp);
   endtask

   task automatic wr_addr(input logic [31:0] a, input logic [31:0] d);
      bus.memaddr      = a;
      bus.memwritedata = d;
      bus.memwrite     = 1'b1;
      @(posedge clk);
      #1;
      bus.memwrite = 1'b0;
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d);
      wr_addr(BASE + {27'd0, off, 2'b00}, d);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset            = 1'b0;
      bus.memwrite     = 1'b0;
      bus.memaddr      = 32'd0;
      bus.memwritedata = 32'd0;
      #1;
      check("rst_irq", {31'd0, irq}, 32'd0);
      chk_reg("rst_ctrl", CTRL, 32'd0);
      chk_reg("rst_count", COUNT, 32'd0);
      @(negedge clk) reset = 1'b1;
      idle(1);

      // One-shot: ticks every cycle, COUNT 3 expires on the 4th edge after enabling.
      wr(PRESC, 32'd0);
      wr(COUNT, 32'd3);
      wr(CTRL, 32'h5);
      idle(3);
      chk_reg("os_status_pre", STATUS, 32'd0);
      check("os_irq_pre", {31'd0, irq}, 32'd0);
      chk_reg("os_count_pre", COUNT, 32'd0);
      idle(1);
      check("os_irq", {31'd0, irq}, 32'd1);
      chk_reg("os_status", STATUS, 32'd1);
      chk_reg("os_ctrl", CTRL, 32'h4);
      chk_reg("os_count", COUNT, 32'd0);
      for (int i = 0; i < 10; i++) begin
         idle(1);
         chk_reg("os_count_hold", COUNT, 32'd0);
      end

      // Auto-reload: PRESC=2, LOAD=1 -> expiry every 6 cycles.
      wr(CTRL, 32'h0);
      wr(STATUS, 32'h1);
      check("ar_irq_clr", {31'd0, irq}, 32'd0);
      wr(PRESC, 32'd2);
      wr(LOAD, 32'd1);
      wr(COUNT, 32'd1);
      wr(CTRL, 32'h3);
      idle(5);
      chk_reg("ar_status_e5", STATUS, 32'd0);
      idle(1);
      chk_reg("ar_status_e6", STATUS, 32'd1);
      chk_reg("ar_count_e6", COUNT, 32'd1);
      check("ar_irq_off", {31'd0, irq}, 32'd0);
      wr(STATUS, 32'h0);
      chk_reg("ar_w0_keeps", STATUS, 32'd1);
      wr(STATUS, 32'h1);
      chk_reg("ar_w1_clears", STATUS, 32'd0);
      idle(3);
      chk_reg("ar_status_e11", STATUS, 32'd0);
      idle(1);
      chk_reg("ar_status_e12", STATUS, 32'd1);
      chk_reg("ar_count_e12", COUNT, 32'd1);

      // COUNT write in a tick cycle wins over the decrement.
      wr(CTRL, 32'h0);
      wr(PRESC, 32'd0);
      wr(LOAD, 32'd100);
      wr(COUNT, 32'd50);
      wr(CTRL, 32'h3);
      idle(2);
      chk_reg("col_count_run", COUNT, 32'd48);
      wr(COUNT, 32'h10);
      chk_reg("col_count_wr", COUNT, 32'h10);
      idle(1);
      chk_reg("col_count_next", COUNT, 32'h0F);

      // W1C on STATUS in the expiry cycle: set wins.
      wr(CTRL, 32'h0);
      wr(STATUS, 32'h1);
      chk_reg("w1c_pre_clear", STATUS, 32'd0);
      wr(LOAD, 32'd5);
      wr(COUNT, 32'd2);
      wr(CTRL, 32'h3);
      idle(2);
      chk_reg("w1c_count0", COUNT, 32'd0);
      chk_reg("w1c_status_pre", STATUS, 32'd0);
      wr(STATUS, 32'h1);
      chk_reg("w1c_set_wins", STATUS, 32'd1);
      chk_reg("w1c_reload", COUNT, 32'd5);
      wr(CTRL, 32'h0);

      // Decode: holes, misalignment, out-of-block, unimplemented bits.
      wr_addr(BASE + 32'h14, 32'hFFFF_FFFF);
      #1;
      check("dec_14_sel", {31'd0, bus.sel}, 32'd1);
      check("dec_14_rdata", bus.rdata, 32'd0);
      wr_addr(BASE + 32'h1C, 32'hFFFF_FFFF);
      #1;
      check("dec_1c_rdata", bus.rdata, 32'd0);
      wr_addr(BASE + 32'h02, 32'h0000_0007);
      #1;
      check("dec_mis_sel", {31'd0, bus.sel}, 32'd0);
      check("dec_mis_rdata", bus.rdata, 32'd0);
      chk_reg("dec_mis_ctrl", CTRL, 32'd0);
      wr_addr(BASE + 32'h20, 32'h0000_0007);
      #1;
      check("dec_20_sel", {31'd0, bus.sel}, 32'd0);
      check("dec_20_rdata", bus.rdata, 32'd0);
      chk_reg("dec_20_ctrl", CTRL, 32'd0);
      wr(PRESC, 32'hFFFF_0007);
      chk_reg("dec_presc_w", PRESC, 32'h0000_0007);
      wr(CTRL, 32'hFFFF_FFF8);
      chk_reg("dec_ctrl_hi", CTRL, 32'd0);

      // Asynchronous reset mid-count (expired still set from the W1C test).
      wr(PRESC, 32'd3);
      wr(LOAD, 32'd7);
      wr(COUNT, 32'd5);
      wr(CTRL, 32'h7);
      check("ar_irq_before", {31'd0, irq}, 32'd1);
      chk_reg("ar_count_before", COUNT, 32'd5);
      reset = 1'b0;
      #1;
      check("arst_irq", {31'd0, irq}, 32'd0);
      chk_reg("arst_ctrl", CTRL, 32'd0);
      chk_reg("arst_load", LOAD, 32'd0);
      chk_reg("arst_count", COUNT, 32'd0);
      chk_reg("arst_status", STATUS, 32'd0);
      chk_reg("arst_presc", PRESC, 32'd0);
      check("arst_sel", {31'd0, bus.sel}, 32'd1);
      @(negedge clk) reset = 1'b1;
      idle(3);
      chk_reg("post_rst_ctrl", CTRL, 32'd0);
      chk_reg("post_rst_count", COUNT, 32'd0);
      check("post_rst_irq", {31'd0, irq}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_timer.md
Name: mips_timer

Overview:
- Memory-mapped down-counting timer on the data-memory side of the pipelined MIPS core.
- Consumes the core's MEM-stage bus (memwrite, memaddr, memwritedata).
- Returns read data in the same cycle, so the core's WB-stage register captures it like a RAM word.
- Provides a prescaled tick, one-shot or auto-reload modes, and a level interrupt.

Parameters:
- BASE_ADDR, 32'hFFFF_0100, byte address of register block; must be 32-byte aligned.
- PRESC_W, 16, width of prescaler divisor and prescaler counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- memwrite  input  1  store strobe from core MEM stage.
- memaddr  input  32  byte address from core MEM stage.
- memwritedata  input  32  store data.
- sel  output  1  address hit; system read mux selects rdata when 1.
- rdata  output  32  register read data (combinational on memaddr).
- irq  output  1  interrupt request, level.

Behaviour:
- Decode:
  - hit = (memaddr[31:5] == BASE_ADDR[31:5]) & (memaddr[1:0] == 0).
  - sel = hit.
  - Write occurs on rising clk when hit & memwrite.
  - Reads have no side effects.
- Register map (offset = memaddr[4:2]):
  - 0 CTRL: [0] en, [1] reload, [2] irq_en; other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: read returns live counter; write sets counter.
  - 3 STATUS: [0] expired; write 1 to clear, write 0 no effect.
  - 4 PRESC: [PRESC_W-1:0] divisor; upper bits read 0.
  - 5-7: read 0, writes ignored.
- rdata = 0 when no hit.
- Reset (reset=0, asynchronous): CTRL, LOAD, COUNT, STATUS, PRESC and the prescaler counter pcnt are all cleared to 0.
  - irq=0.
  - sel/rdata follow memaddr only.
- Prescaler:
  - While en=1: tick = (pcnt == PRESC).
  - On tick, pcnt <= 0; otherwise pcnt <= pcnt + 1.
  - While en=0, pcnt held at 0.
  - PRESC=0 gives a tick every cycle.
  - A write to CTRL that changes en 0->1 clears pcnt; the first tick comes PRESC+1 cycles after the write edge.
- Counter, on tick:
  - If COUNT != 0: COUNT <= COUNT - 1.
  - If COUNT == 0: expired <= 1; then
    - reload=1: COUNT <= LOAD.
    - reload=0: en <= 0, and COUNT stays 0 (one-shot).
  - Period in auto-reload is (LOAD+1)*(PRESC+1) cycles.
- irq = expired & irq_en, both registered; no combinational path from the bus to irq.
- Simultaneous events:
  - Software write to COUNT in a tick cycle: the written value wins; the tick's decrement or reload is discarded.
  - Expiry in the same cycle as a W1C to STATUS: expired ends at 1 (set wins).
  - Software write to CTRL in a cycle where one-shot expiry clears en: the written CTRL value wins.
  - Writing PRESC below the current pcnt: pcnt continues upward and wraps at 2^PRESC_W before matching. This is accepted behaviour; software changes PRESC only with en=0.
- Reset asserted mid-count: all state clears immediately, with no clock needed.
- Reset deasserted: the timer is idle (en=0).

Test Plan:
- Reset check: assert reset=0 mid-count with COUNT=5, en=1. All registers must read 0 and irq=0 immediately, without a clock edge.
- One-shot:
  - Setup: PRESC=0, COUNT=3, CTRL=0x5 (en, irq_en).
  - Expiry: expired=1 and irq=1 exactly 4 cycles after the CTRL write edge.
  - After expiry: COUNT=0, CTRL.en=0, and COUNT stays 0 for another 10 cycles.
- Auto-reload with prescaler:
  - Setup: PRESC=2, LOAD=1, COUNT=1, CTRL=0x3 (en, reload).
  - Expiry: expired must set every 6 cycles.
  - Clearing: writing STATUS=1 between expiries clears expired; a write of 0 leaves it set.
- Collisions:
  - Write COUNT=0x10 in a tick cycle: the read-back must be 0x10, not 0x0F.
  - Issue a W1C to STATUS in the expiry cycle: expired must read 1.
- Decode:
  - Accesses to BASE+0x14, BASE+0x1C, and BASE+0x02 (misaligned) must be ignored on write and read as 0.
  - Misaligned access sel: BASE+0x02 must give sel=0.
  - Non-hit rdata: an access to BASE+0x20 must give sel=0 and rdata=0.
